leaderboard_sorter: RTL and testbench

LEADERBOARD_SORTER -- requirements
Module: leaderboard_sorter

---
 rtl/leaderboard_sorter.sv | 184 ++++++++++++++++++
 tb/tb_leaderboard_sorter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leaderboard_sorter.sv
// rtl/leaderboard_sorter.sv - sorted best-first score leaderboard with one-entry-per-cycle insertion shift.
// Define LEADERBOARD_TAG_EN to add per-slot player tags (in_tag/rd_tag).
module leaderboard_sorter #(
    parameter int W             = 10,
    parameter int DEPTH         = 5,
    parameter int TAG_W         = 4,
    parameter int HIGHER_BETTER = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_score,
`ifdef LEADERBOARD_TAG_EN
    input  logic [TAG_W-1:0]             in_tag,
    output logic [TAG_W-1:0]             rd_tag,
`endif
    input  logic [$clog2(DEPTH)-1:0]     rd_idx,
    output logic [W-1:0]                 rd_score,
    output logic                         rd_occ,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   rank
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || DEPTH > 32 || TAG_W < 1 || W < 1) begin : g_bad_params
        $error("leaderboard_sorter: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, SEARCH, SHIFT, WRITE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_score [DEPTH];
    logic [DEPTH-1:0] r_occ;
    logic [W-1:0]    r_new_score;
`ifdef LEADERBOARD_TAG_EN
    logic [TAG_W-1:0] r_tag [DEPTH];
    logic [TAG_W-1:0] r_new_tag;
`endif
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_p;
    logic [CW-1:0]   r_rank;
    logic [IW-1:0]   r_j;
    logic            r_done;
    logic [CW-1:0]   w_p;
    logic [CW-1:0]   w_jstart;
    logic            w_clear;
    logic            w_accept;
    logic            w_shift;
    logic            w_write;

    function automatic logic better_eq(input logic [W-1:0] a, input logic [W-1:0] b);
        return (HIGHER_BETTER != 0) ? (a >= b) : (a <= b);
    endfunction

    // Ties count as "ahead", so an equal newcomer lands after existing equals.
    always_comb begin
        w_p = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_occ[i] && better_eq(r_score[i], r_new_score)) begin
                w_p = w_p + CW'(1);
            end
        end
        w_jstart = (r_count > CW'(DEPTH-1)) ? CW'(DEPTH-1) : r_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!clear && in_valid && in_score != '0) w_next = SEARCH;
            SEARCH:  w_next = (w_p < CW'(DEPTH) && w_jstart > w_p) ? SHIFT : WRITE;
            SHIFT:   if (CW'(r_j) == r_p + CW'(1)) w_next = WRITE;
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == IDLE) && !clear;
        w_clear  = (r_state == IDLE) && clear;
        w_accept = in_ready && in_valid && (in_score != '0);
        w_shift  = (r_state == SHIFT);
        w_write  = (r_state == WRITE) && (r_p < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_score[i] <= '0;
`ifdef LEADERBOARD_TAG_EN
                r_tag[i]   <= '0;
`endif
            end
            r_occ       <= '0;
            r_new_score <= '0;
`ifdef LEADERBOARD_TAG_EN
            r_new_tag   <= '0;
`endif
            r_count     <= '0;
            r_p         <= '0;
            r_j         <= '0;
            r_rank      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == WRITE);
            if (r_state == WRITE) r_rank <= r_p;

            if (w_clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_score[i] <= '0;
`ifdef LEADERBOARD_TAG_EN
                    r_tag[i]   <= '0;
`endif
                end
                r_occ   <= '0;
                r_count <= '0;
            end

            if (w_accept) begin
                r_new_score <= in_score;
`ifdef LEADERBOARD_TAG_EN
                r_new_tag   <= in_tag;
`endif
            end

            if (r_state == SEARCH) begin
                r_p <= w_p;
                r_j <= w_jstart[IW-1:0];
            end

            // Shifting from the tail toward p drops the last entry when the board is full.
            if (w_shift) begin
                r_score[r_j] <= r_score[r_j - IW'(1)];
                r_occ[r_j]   <= r_occ[r_j - IW'(1)];
`ifdef LEADERBOARD_TAG_EN
                r_tag[r_j]   <= r_tag[r_j - IW'(1)];
`endif
                r_j <= r_j - IW'(1);
            end

            if (w_write) begin
                r_score[r_p[IW-1:0]] <= r_new_score;
                r_occ[r_p[IW-1:0]]   <= 1'b1;
`ifdef LEADERBOARD_TAG_EN
                r_tag[r_p[IW-1:0]]   <= r_new_tag;
`endif
                r_count <= (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
            end
        end
    end

    always_comb begin
        rd_score = '0;
        rd_occ   = 1'b0;
`ifdef LEADERBOARD_TAG_EN
        rd_tag   = '0;
`endif
        if (int'(rd_idx) < DEPTH && r_occ[rd_idx]) begin
            rd_score = r_score[rd_idx];
            rd_occ   = 1'b1;
`ifdef LEADERBOARD_TAG_EN
            rd_tag   = r_tag[rd_idx];
`endif
        end
    end

    assign count = r_count;
    assign done  = r_done;
    assign rank  = r_rank;

endmodule

// File: tb/tb_leaderboard_sorter.sv
// tb/tb_leaderboard_sorter.sv - bench for leaderboard_sorter against a queue-based ranking model.
module tb_leaderboard_sorter;

    localparam int W     = 10;
    localparam int DEPTH = 5;
    localparam int TAG_W = 4;
    localparam int IW    = 3;
    localparam int CW    = 3;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          reset;
    logic          clear, in_valid, in_ready, rd_occ, done;
    logic [W-1:0]  in_score, rd_score;
    logic [IW-1:0] rd_idx;
    logic [CW-1:0] count, rank;
    logic          hb_clear, hb_valid, hb_ready, hb_rd_occ, hb_done;
    logic [W-1:0]  hb_score, hb_rd_score;
    logic [IW-1:0] hb_rd_idx;
    logic [CW-1:0] hb_count, hb_rank;
`ifdef LEADERBOARD_TAG_EN
    logic [TAG_W-1:0] in_tag, rd_tag, hb_tag, hb_rd_tag;
`endif

    leaderboard_sorter #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .HIGHER_BETTER(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_score(in_score),
`ifdef LEADERBOARD_TAG_EN
        .in_tag(in_tag), .rd_tag(rd_tag),
`endif
        .rd_idx(rd_idx), .rd_score(rd_score), .rd_occ(rd_occ),
        .count(count), .done(done), .rank(rank)
    );

    leaderboard_sorter #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .HIGHER_BETTER(1)) dut_hb (
        .clk(clk), .reset(reset), .clear(hb_clear), .in_valid(hb_valid), .in_ready(hb_ready),
        .in_score(hb_score),
`ifdef LEADERBOARD_TAG_EN
        .in_tag(hb_tag), .rd_tag(hb_rd_tag),
`endif
        .rd_idx(hb_rd_idx), .rd_score(hb_rd_score), .rd_occ(hb_rd_occ),
        .count(hb_count), .done(hb_done), .rank(hb_rank)
    );

    int checks = 0;
    int errors = 0;
    int q_score [2][$];
    int q_tag   [2][$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    function automatic logic ready_of(input int h);  return h != 0 ? hb_ready : in_ready; endfunction
    function automatic logic done_of(input int h);   return h != 0 ? hb_done  : done;     endfunction
    function automatic logic [CW-1:0] rank_of(input int h);  return h != 0 ? hb_rank  : rank;  endfunction
    function automatic logic [CW-1:0] count_of(input int h); return h != 0 ? hb_count : count; endfunction

    // Reference: entry goes after every entry that is at least as good; board truncated to DEPTH.
    task automatic model_insert(input int h, input int s, input int t, output int rk, output int k);
        int p;
        int keep;
        p = 0;
        for (int i = 0; i < q_score[h].size(); i++) begin
            if (h != 0 ? (q_score[h][i] >= s) : (q_score[h][i] <= s)) p++;
        end
        keep = (q_score[h].size() < DEPTH) ? q_score[h].size() : DEPTH - 1;
        k = (p < DEPTH && keep > p) ? keep - p : 0;
        if (p < DEPTH) begin
            q_score[h].insert(p, s);
            q_tag[h].insert(p, t);
            if (q_score[h].size() > DEPTH) begin
                void'(q_score[h].pop_back());
                void'(q_tag[h].pop_back());
            end
            rk = p;
        end else begin
            rk = DEPTH;
        end
    endtask

    task automatic drive(input int h, input logic v, input int s, input int t);
        if (h == 0) begin
            in_valid = v;
            in_score = W'(s);
`ifdef LEADERBOARD_TAG_EN
            in_tag   = TAG_W'(t);
`endif
        end else begin
            hb_valid = v;
            hb_score = W'(s);
`ifdef LEADERBOARD_TAG_EN
            hb_tag   = TAG_W'(t);
`endif
        end
    endtask

    task automatic check_board(input int h);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (h == 0) rd_idx = IW'(i); else hb_rd_idx = IW'(i);
            #1;
            if (i < q_score[h].size()) begin
                check("slot_occ",   h != 0 ? hb_rd_occ : rd_occ, 1);
                check("slot_score", h != 0 ? hb_rd_score : rd_score, q_score[h][i]);
`ifdef LEADERBOARD_TAG_EN
                check("slot_tag",   h != 0 ? hb_rd_tag : rd_tag, q_tag[h][i]);
`endif
            end else begin
                check("empty_occ",   h != 0 ? hb_rd_occ : rd_occ, 0);
                check("empty_score", h != 0 ? hb_rd_score : rd_score, 0);
`ifdef LEADERBOARD_TAG_EN
                check("empty_tag",   h != 0 ? hb_rd_tag : rd_tag, 0);
`endif
            end
        end
    endtask

    task automatic submit(input int h, input int s, input int t);
        int  rk, k, lo;
        bit  got;
        model_insert(h, s, t, rk, k);
        @(negedge clk);
        check("ready_before", ready_of(h), 1);
        drive(h, 1'b1, s, t);
        @(posedge clk); #1;
        drive(h, 1'b0, 0, 0);
        lo  = 0;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (!ready_of(h)) lo++;
            if (done_of(h)) got = 1;
            else begin @(posedge clk); #1; end
        end
        check("done_seen", got, 1);
        check("rank", rank_of(h), rk);
        check("ready_low_cycles", lo, 2 + k);
        check("count", count_of(h), q_score[h].size());
        @(posedge clk); #1;
        check("done_one_cycle", done_of(h), 0);
        check_board(h);
    endtask

    task automatic clear_board(input int h);
        @(negedge clk);
        if (h == 0) clear = 1'b1; else hb_clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; hb_clear = 1'b0;
        q_score[h].delete();
        q_tag[h].delete();
        check("count_after_clear", count_of(h), 0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; hb_clear = 1'b0; rd_idx = '0; hb_rd_idx = '0;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("reset_ready", in_ready, 1);
        check("reset_count", count, 0);
        check("reset_done", done, 0);
        check("reset_rank", rank, 0);
        check("reset_hb_ready", hb_ready, 1);
        check_board(0);

        // Out-of-order inserts settle sorted ascending.
        submit(0, 50, 1); submit(0, 30, 2); submit(0, 40, 3);
        check("s029_count", count, 3);

        // Full board: worse entry not placed; middle entry shifts two.
        clear_board(0);
        for (int i = 1; i <= 5; i++) submit(0, 10 * i, i);
        submit(0, 60, 6);
        submit(0, 25, 7);

        // Zero score is swallowed without effect.
        @(negedge clk); drive(0, 1'b1, 0, 9);
        @(posedge clk); #1; drive(0, 1'b0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            check("zero_no_done", done, 0);
            check("zero_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        check("zero_count", count, q_score[0].size());
        check_board(0);

        // Reset mid-shift: 5 goes to slot 0 on a full board, so SHIFT lasts several cycles.
        @(negedge clk); drive(0, 1'b1, 5, 1);
        @(posedge clk); #1; drive(0, 1'b0, 0, 0);
        @(posedge clk); #1;
        check("in_shift_busy", in_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        q_score[0].delete(); q_tag[0].delete();
        check("rst_shift_count", count, 0);
        check("rst_shift_ready", in_ready, 1);
        check("rst_shift_done", done, 0);
        @(posedge clk); #1;
        check("rst_shift_done_after", done, 0);
        check_board(0);

        // Equal scores keep arrival order.
        submit(0, 20, 1); submit(0, 20, 2);
        check("tie_count", count, 2);

        // Clear beats a simultaneous submission.
        @(negedge clk); clear = 1'b1; drive(0, 1'b1, 33, 3);
        #1; check("clear_blocks_ready", in_ready, 0);
        @(posedge clk); #1; clear = 1'b0; drive(0, 1'b0, 0, 0);
        q_score[0].delete(); q_tag[0].delete();
        for (int c = 0; c < 4; c++) begin
            check("clear_no_done", done, 0);
            @(posedge clk); #1;
        end
        check("clear_count", count, 0);
        check_board(0);

        // Higher-is-better instance.
        submit(1, 5, 1); submit(1, 9, 2); submit(1, 7, 3);

        // Randomized traffic with frequent ties and occasional clears.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 11) == 0) clear_board(0);
            submit(0, int'($urandom_range(1, 40)), int'($urandom_range(0, 15)));
        end
        for (int n = 0; n < 15; n++) begin
            submit(1, int'($urandom_range(1, 1023)), int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
